// File: rtl/pipeline_pkg.sv
// Shared types for the fetch/LSU memory port arbiter.
package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  bytemask;
    logic        valid;
  } mem_req_t;

  localparam logic [3:0] FETCH_MASK = 4'b1111;

  // Instruction fetches are always full-word reads.
  function automatic mem_req_t fetch_req(input logic [31:0] addr);
    mem_req_t r;
    r.addr     = addr;
    r.we       = 1'b0;
    r.wdata    = 32'h0;
    r.bytemask = FETCH_MASK;
    r.valid    = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/arb_priority_sel.sv
// Winner select between fetch and LSU; LSU has priority unless fetch is starved.
// Purely combinational, zero latency; no backpressure of its own.
module arb_priority_sel (
  input  logic if_req,
  input  logic ls_req,
  input  logic starved,
  output logic grant_if,
  output logic grant_ls
);

  assign grant_if = if_req & (~ls_req | starved);
  assign grant_ls = ls_req & ~grant_if;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester single-outstanding memory port arbiter; accept-to-response 3 cycles minimum.
// Ready only in IDLE for the winner; o_mem_valid holds until i_mem_ready.
import pipeline_pkg::*;

module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_valid,
  input  logic [31:0] i_if_addr,
  input  logic        i_if_flush,
  output logic        o_if_ready,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_ls_valid,
  input  logic [31:0] i_ls_addr,
  input  logic        i_ls_we,
  input  logic [31:0] i_ls_wdata,
  input  logic [3:0]  i_ls_bytemask,
  output logic        o_ls_ready,
  output logic        o_ls_rvalid,
  output logic [31:0] o_ls_rdata,
  output logic        o_mem_valid,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bytemask,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_protocol_err
);

  arb_state_t state_q;
  arb_owner_t owner_q;
  mem_req_t   req_q;
  logic [2:0] starve_cnt;
  logic       drop_q;
  logic       starved;
  logic       sel_if;
  logic       sel_ls;
  logic       is_idle;
  logic       flush_hit;

  assign is_idle   = (state_q == IDLE);
  assign starved   = (starve_cnt == 3'(STARVE_LIMIT));
  assign flush_hit = i_if_flush && (owner_q == OWN_IF);

  // A flushing fetch cannot win, so the LSU sees normal arbitration that cycle.
  arb_priority_sel u_sel (
    .if_req   (i_if_valid & ~i_if_flush),
    .ls_req   (i_ls_valid),
    .starved  (starved),
    .grant_if (sel_if),
    .grant_ls (sel_ls)
  );

  assign o_if_ready     = is_idle & sel_if;
  assign o_ls_ready     = is_idle & sel_ls;
  assign o_mem_valid    = req_q.valid;
  assign o_mem_addr     = req_q.addr;
  assign o_mem_we       = req_q.we;
  assign o_mem_wdata    = req_q.wdata;
  assign o_mem_bytemask = req_q.bytemask;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= IDLE;
      owner_q        <= OWN_IF;
      req_q          <= '0;
      starve_cnt     <= 3'd0;
      drop_q         <= 1'b0;
      o_if_rvalid    <= 1'b0;
      o_ls_rvalid    <= 1'b0;
      o_if_rdata     <= 32'h0;
      o_ls_rdata     <= 32'h0;
      o_protocol_err <= 1'b0;
    end else begin
      o_if_rvalid <= 1'b0;
      o_ls_rvalid <= 1'b0;
      if (i_mem_rvalid && (state_q != WAIT_RSP)) o_protocol_err <= 1'b1;
      case (state_q)
        IDLE: begin
          if (o_if_ready) begin
            owner_q    <= OWN_IF;
            req_q      <= fetch_req(i_if_addr);
            starve_cnt <= 3'd0;
            state_q    <= ISSUE;
          end else if (o_ls_ready) begin
            owner_q        <= OWN_LS;
            req_q.addr     <= i_ls_addr;
            req_q.we       <= i_ls_we;
            req_q.wdata    <= i_ls_wdata;
            req_q.bytemask <= i_ls_bytemask;
            req_q.valid    <= 1'b1;
            if (i_if_valid && !starved) starve_cnt <= starve_cnt + 3'd1;
            state_q        <= ISSUE;
          end
        end
        ISSUE: begin
          if (flush_hit) drop_q <= 1'b1;
          if (i_mem_ready) begin
            req_q.valid <= 1'b0;
            state_q     <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (flush_hit) drop_q <= 1'b1;
          if (i_mem_rvalid) begin
            // A flush arriving with the response still kills the fetch reply.
            if (owner_q == OWN_LS) begin
              o_ls_rvalid <= 1'b1;
              o_ls_rdata  <= i_mem_rdata;
            end else if (!drop_q && !i_if_flush) begin
              o_if_rvalid <= 1'b1;
              o_if_rdata  <= i_mem_rdata;
            end
            drop_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum consecutive LSU grants while fetch waits (range 1..7).
REQ-002 SHALL have port i_clk, input, 1, the single clock; all logic is on the rising edge.
REQ-003 SHALL have port i_rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have fetch-side request ports: i_if_valid in 1; i_if_addr in 32; i_if_flush in 1 (cancel the outstanding fetch); o_if_ready out 1.
REQ-005 SHALL have fetch-side response ports: o_if_rvalid out 1; o_if_rdata out 32.
REQ-006 SHALL have LSU-side request ports: i_ls_valid in 1; i_ls_addr in 32; i_ls_we in 1; i_ls_wdata in 32; i_ls_bytemask in 4; o_ls_ready out 1.
REQ-007 SHALL have LSU-side response ports: o_ls_rvalid out 1; o_ls_rdata out 32.
REQ-008 SHALL have memory-side ports: o_mem_valid out 1; o_mem_addr out 32; o_mem_we out 1; o_mem_wdata out 32; o_mem_bytemask out 4; i_mem_ready in 1; i_mem_rvalid in 1; i_mem_rdata in 32.
REQ-009 SHALL have port o_protocol_err, output, 1: a sticky flag set by an unexpected memory response.

Function
REQ-010 SHALL implement the FSM states IDLE, ISSUE and WAIT_RSP, with at most one outstanding memory transaction.
REQ-011 IDLE: SHALL grant the requester with valid high; when both are valid, LSU wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
REQ-012 o_if_ready/o_ls_ready SHALL be combinational: high only in IDLE, only for the winner, and zero in every other state.
REQ-013 On acceptance (valid & ready), SHALL latch the owner, addr, we, wdata and bytemask, then move to ISSUE next cycle.
REQ-014 A fetch request SHALL carry we=0 and bytemask=4'b1111.
REQ-015 ISSUE: o_mem_valid=1 with the latched fields held stable; o_mem_valid SHALL NOT drop before i_mem_ready; on i_mem_ready move to WAIT_RSP.
REQ-016 WAIT_RSP: on i_mem_rvalid, SHALL register i_mem_rdata into the owner's rdata and pulse the owner's rvalid for exactly 1 cycle on the next cycle, then return to IDLE.
REQ-017 An LSU write SHALL still wait for i_mem_rvalid, which acts as the write acknowledge; o_ls_rvalid pulses and o_ls_rdata carries i_mem_rdata.
REQ-018 Minimum latency SHALL be: accept at cycle 0, mem handshake at cycle 1, i_mem_rvalid at cycle 2 earliest, o_*_rvalid at cycle 3; back-to-back accept is possible at cycle 3.
REQ-019 Flush: i_if_flush while the owner is fetch in ISSUE or WAIT_RSP SHALL set drop_q; the memory transaction completes normally, o_if_rvalid is suppressed, and drop_q clears on return to IDLE.
REQ-020 i_if_flush high in IDLE SHALL force o_if_ready=0 that cycle, with LSU arbitration unaffected.
REQ-021 Flush coincident with i_mem_rvalid in WAIT_RSP SHALL still suppress o_if_rvalid.
REQ-022 starve_cnt (3 bits) SHALL increment on an LSU grant while i_if_valid=1, clear on any fetch grant, and saturate at STARVE_LIMIT.
REQ-023 i_mem_rvalid in IDLE or ISSUE SHALL be ignored for data and SHALL set o_protocol_err until reset.
REQ-024 Request inputs SHALL be ignored outside IDLE; requesters hold valid until ready.

Reset
REQ-025 On i_rst, the next state SHALL be IDLE; starve_cnt=0; drop_q=0; o_protocol_err=0.
REQ-026 On i_rst, o_mem_valid, o_if_rvalid and o_ls_rvalid SHALL be 0; latched fields and rdata SHALL be 32'h0.
REQ-027 Reset mid-transaction SHALL abandon the pending transaction with no response pulse, and any later i_mem_rvalid SHALL be flagged per REQ-023.

Structure
REQ-028 pipeline_pkg SHALL hold: arb_state_t (IDLE/ISSUE/WAIT_RSP), arb_owner_t (OWN_IF/OWN_LS), and the mem_req_t struct (addr, we, wdata, bytemask, valid).
REQ-029 SHALL contain one sub-module, arb_priority_sel, the combinational winner select from the two valids plus the starvation flag.

Verification
REQ-030 Fetch only: addr 32'h0000_0100, mem ready immediate, rvalid at cycle 2 with 32'h0000_0013 -> o_if_rvalid=1 at cycle 3, o_if_rdata=32'h0000_0013.
REQ-031 Both requesting, starve_cnt=0 -> LSU granted first; after 4 consecutive LSU grants with fetch held valid, the 5th grant goes to fetch and starve_cnt returns to 0.
REQ-032 LSU write: addr 32'h0000_2000, wdata 32'hDEAD_BEEF, bytemask 4'b0011, i_mem_ready low 3 cycles -> o_mem_* stable for 4 cycles; o_ls_rvalid pulses after the ack.
REQ-033 Fetch in WAIT_RSP plus i_if_flush pulse -> i_mem_rvalid consumed, no o_if_rvalid, FSM in IDLE the next cycle and accepting a new request.
REQ-034 i_mem_rvalid pulse while IDLE -> o_protocol_err=1 and stays 1 until i_rst, with no response pulse on either side.
REQ-035 i_rst asserted in ISSUE -> next cycle IDLE, o_mem_valid=0, and no rvalid pulse on either side.
